// File: rtl/branch_presolve_pkg.sv
// Pre-decode constants, CFI classification and J-immediate extraction for the branch presolver.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable (no handshake in this package).
package branch_presolve_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_JALR    = 3'b000;
  // funct3 values with BRANCH opcode that are not real branches
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [4:0] REG_RA     = 5'd1;

  typedef enum logic [2:0] {NONE, BR, JAL, JALR, CALL, RET} cfi_kind_e;

  // J-type immediate: imm[20|10:1|11|19:12] lives in inst[31:12]; bit 0 is always zero
  function automatic logic [20:0] jal_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Classify one instruction; CALL and RET are the RAS-relevant subsets of JAL and JALR
  function automatic cfi_kind_e decode_cfi(input logic [31:0] inst);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    cfi_kind_e  kind;
    opc  = inst[6:0];
    rd   = inst[11:7];
    f3   = inst[14:12];
    rs1  = inst[19:15];
    kind = NONE;
    if (opc == OPC_JAL) begin
      kind = (rd == REG_RA) ? CALL : JAL;
    end else if (opc == OPC_JALR && f3 == F3_JALR) begin
      kind = (rd == 5'd0 && rs1 == REG_RA && inst[31:20] == 12'd0) ? RET : JALR;
    end else if (opc == OPC_BRANCH && f3 != F3_BR_RSV0 && f3 != F3_BR_RSV1) begin
      kind = BR;
    end
    return kind;
  endfunction

endpackage

// File: rtl/branch_presolve_ras.sv
// Circular return-address stack; push overwrites the oldest entry when full, pop on empty is a no-op.
// Latency: push/pop take effect at the clock edge; top and count are registered state.
// Backpressure: none, the caller issues at most one push or pop per cycle.
module branch_presolve_ras #(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // next write slot; top is the slot below it
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];

  // Stack update: pointer wraps freely, count saturates at depth and floors at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_W'(1);
      if (count != CNT_W'(RAS_DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_presolve_multi.sv
// Pre-decodes a fetch pack and emits early redirects (JAL targets, RAS returns, false-taken fixups).
// Latency: one cycle, an accepted pack's redirect is visible right after the accepting edge.
// Backpressure: pack ready while the output register is empty or being drained; output holds while not taken.
module branch_presolve_multi
  import branch_presolve_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int XLEN        = 64,
  parameter int RAS_DEPTH   = 8,
  localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CNT_W      = $clog2(RAS_DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_i_flush,
  input  logic                     io_i_fetch_pack_valid,
  output logic                     io_o_fetch_pack_ready,
  input  logic [FETCH_WIDTH-1:0]   io_i_fetch_pack_valids,
  input  logic [XLEN-1:0]          io_i_fetch_pack_pc,
  input  logic [32*FETCH_WIDTH-1:0] io_i_fetch_pack_insts,
  input  logic                     io_i_bp_valid,
  input  logic                     io_i_bp_taken,
  input  logic [SLOT_W-1:0]        io_i_bp_slot,
  input  logic [XLEN-1:0]          io_i_bp_target,
  output logic                     io_o_presolve_valid,
  input  logic                     io_i_presolve_ready,
  output logic [XLEN-1:0]          io_o_presolve_pc,
  output logic                     io_o_presolve_taken,
  output logic [SLOT_W-1:0]        io_o_presolve_slot,
  output logic [CNT_W-1:0]         io_o_ras_count
);

  localparam int OFF_W = $clog2(4 * FETCH_WIDTH);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              taken;
    logic [SLOT_W-1:0] slot;
  } res_t;

  logic [XLEN-1:0] base;
  cfi_kind_e       kind    [FETCH_WIDTH];
  logic [XLEN-1:0] spc     [FETCH_WIDTH];
  logic [XLEN-1:0] jal_tgt [FETCH_WIDTH];

  logic              j_found, j_is_call, j_is_ret;
  logic [SLOT_W-1:0] j_idx;
  logic [XLEN-1:0]   j_tgt, j_spc, j_target;
  logic              p_valid, p_cfi;
  logic [XLEN-1:0]   p_spc;
  logic              emit, accept;
  res_t              res, out_q;
  logic              out_valid;
  logic [XLEN-1:0]   ras_top;
  logic [CNT_W-1:0]  ras_count;

  // Slot PCs are taken from the pack-aligned base, whatever the pack PC offset is
  assign base = {io_i_fetch_pack_pc[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
    logic [31:0] inst;
    logic [20:0] imm;
    assign inst       = io_i_fetch_pack_insts[32*g +: 32];
    assign imm        = jal_imm(inst);
    assign kind[g]    = io_i_fetch_pack_valids[g] ? decode_cfi(inst) : NONE;
    assign spc[g]     = base + XLEN'(4 * g);
    assign jal_tgt[g] = spc[g] + {{(XLEN-21){imm[20]}}, imm};
  end

  // Lowest JAL/RET slot wins (scan high to low so the last hit is the lowest); also pick the predicted slot
  always_comb begin
    j_found   = 1'b0;
    j_idx     = '0;
    j_is_call = 1'b0;
    j_is_ret  = 1'b0;
    j_tgt     = '0;
    j_spc     = '0;
    p_cfi     = 1'b0;
    p_spc     = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (kind[i] == JAL || kind[i] == CALL || kind[i] == RET) begin
        j_found   = 1'b1;
        j_idx     = SLOT_W'(i);
        j_is_call = (kind[i] == CALL);
        j_is_ret  = (kind[i] == RET);
        j_tgt     = jal_tgt[i];
        j_spc     = spc[i];
      end
      if (SLOT_W'(i) == io_i_bp_slot) begin
        p_cfi = (kind[i] != NONE);
        p_spc = spc[i];
      end
    end
  end

  assign p_valid  = io_i_bp_valid && io_i_bp_taken;
  assign j_target = j_is_ret ? ras_top : j_tgt;

  // Resolution priority: JAL/RET not after the prediction, then false-taken on a non-CFI slot
  always_comb begin
    emit      = 1'b0;
    res.pc    = '0;
    res.taken = 1'b0;
    res.slot  = '0;
    if (j_found && (!p_valid || j_idx <= io_i_bp_slot)) begin
      // empty-RAS return and an already-correct prediction both leave nothing to say
      if (!(j_is_ret && ras_count == '0) &&
          !(p_valid && j_idx == io_i_bp_slot && io_i_bp_target == j_target)) begin
        emit      = 1'b1;
        res.pc    = j_target;
        res.taken = 1'b1;
        res.slot  = j_idx;
      end
    end else if (p_valid && !p_cfi) begin
      emit      = 1'b1;
      res.pc    = p_spc + XLEN'(4);
      res.taken = 1'b0;
      res.slot  = io_i_bp_slot;
    end
  end

  assign io_o_fetch_pack_ready = !out_valid || io_i_presolve_ready;
  assign accept = io_i_fetch_pack_valid && io_o_fetch_pack_ready && !io_i_flush;

  branch_presolve_ras #(
    .RAS_DEPTH(RAS_DEPTH),
    .XLEN     (XLEN)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (accept && j_found && j_is_call),
    .pop      (accept && j_found && j_is_ret),
    .push_data(j_spc + XLEN'(4)),
    .top      (ras_top),
    .count    (ras_count)
  );

  // Output register: flush drops it, an emitting pack loads it, otherwise it drains when taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (io_i_flush) begin
      out_valid <= 1'b0;
    end else if (accept && emit) begin
      out_valid <= 1'b1;
      out_q     <= res;
    end else if (io_i_presolve_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign io_o_presolve_valid = out_valid;
  assign io_o_presolve_pc    = out_q.pc;
  assign io_o_presolve_taken = out_q.taken;
  assign io_o_presolve_slot  = out_q.slot;
  assign io_o_ras_count      = ras_count;

endmodule

// File: tb/tb_branch_presolve_multi.sv
// Directed bench for branch_presolve_multi with a queue-based reference model and literal spot checks.
// Latency: model output register updates on the same edge as the DUT, compared on the falling edge.
// Backpressure: consumer ready is driven by the stimulus; the model tracks the handshake itself.
module tb_branch_presolve_multi;

  localparam int FW = 2;
  localparam int XL = 64;
  localparam int RD = 4;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] RETI = 32'h0000_8067;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          pk_valid = 1'b0;
  logic          pk_ready;
  logic [FW-1:0] pk_valids = '0;
  logic [XL-1:0] pk_pc = '0;
  logic [32*FW-1:0] pk_insts = '0;
  logic          bp_valid = 1'b0;
  logic          bp_taken = 1'b0;
  logic [0:0]    bp_slot = '0;
  logic [XL-1:0] bp_target = '0;
  logic          pr_valid;
  logic          pr_ready = 1'b1;
  logic [XL-1:0] pr_pc;
  logic          pr_taken;
  logic [0:0]    pr_slot;
  logic [2:0]    ras_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  branch_presolve_multi #(.FETCH_WIDTH(FW), .XLEN(XL), .RAS_DEPTH(RD)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_i_flush            (flush),
    .io_i_fetch_pack_valid (pk_valid),
    .io_o_fetch_pack_ready (pk_ready),
    .io_i_fetch_pack_valids(pk_valids),
    .io_i_fetch_pack_pc    (pk_pc),
    .io_i_fetch_pack_insts (pk_insts),
    .io_i_bp_valid         (bp_valid),
    .io_i_bp_taken         (bp_taken),
    .io_i_bp_slot          (bp_slot),
    .io_i_bp_target        (bp_target),
    .io_o_presolve_valid   (pr_valid),
    .io_i_presolve_ready   (pr_ready),
    .io_o_presolve_pc      (pr_pc),
    .io_o_presolve_taken   (pr_taken),
    .io_o_presolve_slot    (pr_slot),
    .io_o_ras_count        (ras_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ---------------- reference model ----------------
  logic          m_valid = 1'b0;
  logic [63:0]   m_pc = '0;
  logic          m_taken = 1'b0;
  logic          m_slot = 1'b0;
  logic          m_rdy;
  logic [63:0]   m_ras[$];

  function automatic logic [63:0] slot_pc(input logic [63:0] pc, input int i);
    return (pc & ~64'h7) + 64'(4 * i);
  endfunction

  function automatic logic [63:0] jimm(input logic [31:0] ins);
    logic signed [63:0] v;
    v = '0;
    v[20]    = ins[31];
    v[10:1]  = ins[30:21];
    v[11]    = ins[20];
    v[19:12] = ins[19:12];
    v = (v <<< 43) >>> 43;
    return v;
  endfunction

  function automatic logic is_cfi(input logic [31:0] ins);
    if (ins[6:0] == 7'h6f) return 1'b1;
    if (ins[6:0] == 7'h67 && ins[14:12] == 3'd0) return 1'b1;
    if (ins[6:0] == 7'h63 && ins[14:12] != 3'd2 && ins[14:12] != 3'd3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept();
    int j;
    int p;
    logic [31:0] ins;
    logic [63:0] tgt;
    logic have;
    j = -1;
    for (int i = FW - 1; i >= 0; i--) begin
      ins = pk_insts[32*i +: 32];
      if (pk_valids[i] && (ins[6:0] == 7'h6f || ins == RETI)) j = i;
    end
    p = (bp_valid && bp_taken) ? int'(bp_slot) : -1;
    if (j >= 0 && (p < 0 || j <= p)) begin
      ins  = pk_insts[32*j +: 32];
      have = 1'b1;
      tgt  = '0;
      if (ins == RETI) begin
        if (m_ras.size() == 0) have = 1'b0;
        else tgt = m_ras[$];
      end else begin
        tgt = slot_pc(pk_pc, j) + jimm(ins);
      end
      if (have && !(p == j && bp_target == tgt)) begin
        m_valid = 1'b1; m_pc = tgt; m_taken = 1'b1; m_slot = 1'(j);
      end
    end else if (p >= 0 && !(pk_valids[p] && is_cfi(pk_insts[32*p +: 32]))) begin
      m_valid = 1'b1; m_pc = slot_pc(pk_pc, p) + 64'd4; m_taken = 1'b0; m_slot = 1'(p);
    end
    if (j >= 0) begin
      ins = pk_insts[32*j +: 32];
      if (ins == RETI) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end else if (ins[11:7] == 5'd1) begin
        m_ras.push_back(slot_pc(pk_pc, j) + 64'd4);
        if (m_ras.size() > RD) void'(m_ras.pop_front());
      end
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_valid = 1'b0; m_pc = '0; m_taken = 1'b0; m_slot = 1'b0;
      m_ras.delete();
    end else begin
      m_rdy = !m_valid || pr_ready;
      if (flush) begin
        m_valid = 1'b0;
      end else begin
        if (pr_ready) m_valid = 1'b0;
        if (pk_valid && m_rdy) model_accept();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("cyc_valid", pr_valid, m_valid);
      check("cyc_fetch_ready", pk_ready, !m_valid || pr_ready);
      check("cyc_ras_count", ras_count, 64'(m_ras.size()));
      if (m_valid) begin
        check("cyc_pc", pr_pc, m_pc);
        check("cyc_taken", pr_taken, m_taken);
        check("cyc_slot", pr_slot, m_slot);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [63:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] v, input logic bt, input logic bs, input logic [63:0] tg);
    pk_pc = pc; pk_insts = {i1, i0}; pk_valids = v;
    bp_valid = bt; bp_taken = bt; bp_slot = bs; bp_target = tg;
    pk_valid = 1'b1;
    @(posedge clock); #1;
    pk_valid = 1'b0; bp_valid = 1'b0; bp_taken = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [63:0] pc,
                            input logic tk, input logic sl);
    check({name, "_valid"}, pr_valid, v);
    if (v) begin
      check({name, "_pc"}, pr_pc, pc);
      check({name, "_taken"}, pr_taken, tk);
      check({name, "_slot"}, pr_slot, sl);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid", pr_valid, 0);
    check("rst_ready", pk_ready, 1);
    check("rst_count", ras_count, 0);
    check("rst_pc", pr_pc, 0);

    // reset while a redirect is pending and the RAS is non-empty
    pr_ready = 1'b0;
    send(64'h3000, jal(5'd1, 21'h01000), ADDI, 2'b01, 0, 0, 0);
    expect_out("t1_load", 1, 64'h4000, 1, 0);
    check("t1_count", ras_count, 1);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_valid", pr_valid, 0);
    check("t1_rst_count", ras_count, 0);
    check("t1_rst_ready", pk_ready, 1);
    @(posedge clock); #1;
    reset = 1'b0; pr_ready = 1'b1;

    // JAL redirect, then the same pack already predicted correctly
    send(64'h1004, ADDI, jal(5'd0, 21'h00100), 2'b10, 0, 0, 0);
    expect_out("t2_jal", 1, 64'h1104, 1, 1);
    send(64'h1004, ADDI, jal(5'd0, 21'h00100), 2'b10, 1, 1, 64'h1104);
    expect_out("t2_match", 0, 0, 0, 0);

    // taken prediction on a plain ALU slot
    send(64'h2000, ADDI, ADDI, 2'b11, 1, 0, 0);
    expect_out("t3_false", 1, 64'h2004, 0, 0);

    // call then return, then return with empty stack
    send(64'h3000, jal(5'd1, 21'h01000), ADDI, 2'b01, 0, 0, 0);
    expect_out("t4_call", 1, 64'h4000, 1, 0);
    check("t4_count1", ras_count, 1);
    send(64'h4008, RETI, ADDI, 2'b01, 0, 0, 0);
    expect_out("t4_ret", 1, 64'h3004, 1, 0);
    check("t4_count0", ras_count, 0);
    send(64'h4008, RETI, ADDI, 2'b01, 0, 0, 0);
    expect_out("t4_empty", 0, 0, 0, 0);

    // overflow: five calls into four entries
    for (int k = 1; k <= 5; k++) begin
      send(64'(16 * k), jal(5'd1, 21'h01000), ADDI, 2'b01, 0, 0, 0);
      check("t5_count", ras_count, (k < 4) ? k : 4);
    end
    for (int k = 0; k < 4; k++) begin
      send(64'h100, RETI, ADDI, 2'b01, 0, 0, 0);
      expect_out("t5_ret", 1, 64'h54 - 64'(16 * k), 1, 0);
    end
    send(64'h100, RETI, ADDI, 2'b01, 0, 0, 0);
    expect_out("t5_ret_empty", 0, 0, 0, 0);
    check("t5_count_end", ras_count, 0);

    // backpressure holds the output, then a flush drops it and the presented pack
    pr_ready = 1'b0;
    send(64'h1004, ADDI, jal(5'd0, 21'h00100), 2'b10, 0, 0, 0);
    pk_pc = 64'h3000; pk_insts = {ADDI, jal(5'd1, 21'h01000)}; pk_valids = 2'b01;
    pk_valid = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check("t6_hold_ready", pk_ready, 0);
      expect_out("t6_hold", 1, 64'h1104, 1, 1);
      check("t6_hold_count", ras_count, 0);
    end
    flush = 1'b1; pr_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; pk_valid = 1'b0;
    check("t6_flush_valid", pr_valid, 0);
    check("t6_flush_count", ras_count, 0);

    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
